// File: rtl/adc_ctrl.sv
// rtl/adc_ctrl.sv - triggered ADC capture controller: pre-delay, N-beat capture, drop-on-stall.
// Optional ADC_CTRL_TIMESTAMP_EN adds a free-running counter latched into trig_timestamp on trigger.
module adc_ctrl #(
  parameter int CFG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [255:0]     s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [255:0]     m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  input  logic             trigger_in,
  input  logic [CFG_W-1:0] cycle_count_cfg,
  input  logic [CFG_W-1:0] pre_delay_cfg,
  output logic             capture_done,
  output logic             overflow_err
`ifdef ADC_CTRL_TIMESTAMP_EN
  ,
  output logic [CFG_W-1:0] trig_timestamp
`endif
);

  typedef enum logic [1:0] {IDLE, PRE, CAPTURE, DONE} state_t;

  localparam logic [CFG_W:0] CNT_ONE = (CFG_W+1)'(1);

  state_t         state_q, state_d;
  logic [CFG_W:0] remain_q, remain_d;
  logic [CFG_W:0] pre_q, pre_d;
  logic [255:0]   tdata_q, tdata_d;
  logic           tvalid_q, tvalid_d;
  logic           tlast_q, tlast_d;
  logic           done_q, done_d;
  logic           ovf_q, ovf_d;
  logic           load;
  logic           last_sample;
`ifdef ADC_CTRL_TIMESTAMP_EN
  logic [CFG_W-1:0] ts_cnt_q, ts_cnt_d;
  logic [CFG_W-1:0] ts_q, ts_d;
`endif

  assign s_axis_tready = 1'b1;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign capture_done  = done_q;
  assign overflow_err  = ovf_q;
`ifdef ADC_CTRL_TIMESTAMP_EN
  assign trig_timestamp = ts_q;
`endif

  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    pre_d       = pre_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q;
    load        = 1'b0;
    last_sample = (remain_q == CNT_ONE);
`ifdef ADC_CTRL_TIMESTAMP_EN
    ts_cnt_d = ts_cnt_q + CFG_W'(1);
    ts_d     = ts_q;
`endif
    case (state_q)
      IDLE: begin
        if (trigger_in && (cycle_count_cfg != '0)) begin
          remain_d = {1'b0, cycle_count_cfg};
          pre_d    = {1'b0, pre_delay_cfg};
          ovf_d    = 1'b0;
          state_d  = (pre_delay_cfg == '0) ? CAPTURE : PRE;
`ifdef ADC_CTRL_TIMESTAMP_EN
          ts_d = ts_cnt_q;
`endif
        end
      end
      PRE: begin
        if (pre_q <= CNT_ONE) begin
          pre_d   = '0;
          state_d = CAPTURE;
        end else begin
          pre_d = pre_q - CNT_ONE;
        end
      end
      CAPTURE: begin
        if (s_axis_tvalid) begin
          remain_d = remain_q - CNT_ONE;
          // A held beat still waiting on the fifo wins; the new beat is lost.
          if (!tvalid_q || m_axis_tready) begin
            load = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
          if (last_sample) begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (!trigger_in) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      tdata_d  = s_axis_tdata;
      tvalid_d = 1'b1;
      tlast_d  = last_sample;
    end else if (m_axis_tready) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      remain_q <= '0;
      pre_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef ADC_CTRL_TIMESTAMP_EN
      ts_cnt_q <= '0;
      ts_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      pre_q    <= pre_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
`ifdef ADC_CTRL_TIMESTAMP_EN
      ts_cnt_q <= ts_cnt_d;
      ts_q     <= ts_d;
`endif
    end
  end

endmodule

// File: tb/tb_adc_ctrl.sv
// tb/tb_adc_ctrl.sv - scoreboard bench for adc_ctrl: capture-window model, queued beats, monitor.
`timescale 1ns/1ps
module tb_adc_ctrl;
  localparam int CFG_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [255:0]     s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic [255:0]     m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic             m_axis_tready;
  logic             trigger_in;
  logic [CFG_W-1:0] cycle_count_cfg;
  logic [CFG_W-1:0] pre_delay_cfg;
  logic             capture_done;
  logic             overflow_err;
`ifdef ADC_CTRL_TIMESTAMP_EN
  logic [CFG_W-1:0] trig_timestamp;
`endif

  adc_ctrl #(.CFG_W(CFG_W)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .trigger_in(trigger_in),
    .cycle_count_cfg(cycle_count_cfg), .pre_delay_cfg(pre_delay_cfg),
    .capture_done(capture_done), .overflow_err(overflow_err)
`ifdef ADC_CTRL_TIMESTAMP_EN
    , .trig_timestamp(trig_timestamp)
`endif
  );

  always #2 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int delivered = 0;
  int done_seen = 0;

  // Reference model: a capture is a window of sample edges starting pre+1 edges after the trigger.
  longint    edge_idx = 0;
  bit        m_active, m_wait_low, m_slot, m_last, m_ovf, m_done;
  longint    m_first, m_rem;
  longint    m_ts_cnt, m_ts;
  logic [256:0] exp_q[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_active = 0; m_wait_low = 0; m_slot = 0; m_last = 0; m_ovf = 0; m_done = 0;
    m_ts_cnt = 0; m_ts = 0;
    exp_q.delete();
  endtask

  task automatic model_edge(input bit trig, input bit tv, input bit tr, input logic [255:0] d,
                            input longint cnt, input longint pre);
    bit consume;
    bit load;
    consume = m_slot && tr;
    load = 0;
    m_done = 0;
    if (m_active) begin
      if (edge_idx >= m_first && tv) begin
        m_rem = m_rem - 1;
        if (!m_slot || tr) begin
          load = 1;
          exp_q.push_back({m_rem == 0, d});
        end else begin
          m_ovf = 1;
        end
        if (m_rem == 0) begin
          m_active = 0; m_wait_low = 1; m_done = 1;
        end
      end
    end else if (m_wait_low) begin
      if (!trig) m_wait_low = 0;
    end else if (trig && cnt != 0) begin
      m_active = 1; m_first = edge_idx + pre + 1; m_rem = cnt; m_ovf = 0;
      m_ts = m_ts_cnt;
    end
    if (load) begin
      m_slot = 1; m_last = (m_rem == 0);
    end else if (consume) begin
      m_slot = 0; m_last = 0;
    end
    m_ts_cnt = (m_ts_cnt + 1) % (64'd1 << CFG_W);
    edge_idx++;
  endtask

  task automatic step(input bit trig, input bit tv, input bit tr);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    trigger_in = trig; s_axis_tvalid = tv; m_axis_tready = tr; s_axis_tdata = d;
    model_edge(trig, tv, tr, d, longint'(cycle_count_cfg), longint'(pre_delay_cfg));
    @(posedge clk);
    #1;
    if (capture_done) done_seen++;
    check("capture_done", 256'(capture_done), 256'(m_done));
    check("overflow_err", 256'(overflow_err), 256'(m_ovf));
    check("m_tvalid", 256'(m_axis_tvalid), 256'(m_slot));
    check("m_tlast", 256'(m_axis_tlast), 256'(m_last));
    check("s_tready", 256'(s_axis_tready), 256'(1));
`ifdef ADC_CTRL_TIMESTAMP_EN
    check("trig_timestamp", 256'(trig_timestamp), 256'(m_ts));
`endif
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_tdata", m_axis_tdata, 256'd0);
    check("rst_tvalid", 256'(m_axis_tvalid), 256'd0);
    check("rst_tlast", 256'(m_axis_tlast), 256'd0);
    check("rst_done", 256'(capture_done), 256'd0);
    check("rst_ovf", 256'(overflow_err), 256'd0);
    check("rst_tready", 256'(s_axis_tready), 256'd1);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: a beat leaves on every edge where valid and ready are both high.
  always @(negedge clk) begin
    if (rst && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL beat_unexpected: got %h want none", m_axis_tdata);
      end else begin
        logic [256:0] e;
        e = exp_q.pop_front();
        check("beat_data", m_axis_tdata, e[255:0]);
        check("beat_last", 256'(m_axis_tlast), 256'(e[256]));
        delivered++;
      end
    end
  end

  int d0, n0;

  initial begin
    rst = 1'b0; trigger_in = 0; s_axis_tvalid = 0; m_axis_tready = 0; s_axis_tdata = '0;
    cycle_count_cfg = 0; pre_delay_cfg = 0;
    model_clear();
    #3;
    do_reset();

    // Basic 4-beat capture, no pre-delay.
    cycle_count_cfg = 4; pre_delay_cfg = 0; d0 = delivered; n0 = done_seen;
    step(1, 1, 1);
    repeat (6) step(0, 1, 1);
    check("basic_beats", 256'(delivered - d0), 256'd4);
    check("basic_done", 256'(done_seen - n0), 256'd1);

    // Pre-delay of 5, cfg changed mid-capture.
    cycle_count_cfg = 3; pre_delay_cfg = 5; d0 = delivered;
    step(1, 1, 1);
    cycle_count_cfg = 9; pre_delay_cfg = 1;
    repeat (10) step(0, 1, 1);
    check("pre_beats", 256'(delivered - d0), 256'd3);

    // Stall during beats 2-3: beat 1 held, 2-3 dropped, beat 4 delivered with tlast.
    cycle_count_cfg = 4; pre_delay_cfg = 0; d0 = delivered;
    step(1, 1, 1);
    step(0, 1, 1); step(0, 1, 0); step(0, 1, 0); step(0, 1, 1);
    repeat (3) step(0, 0, 1);
    check("ovf_beats", 256'(delivered - d0), 256'd2);
    check("ovf_sticky", 256'(overflow_err), 256'd1);

    // Zero count never starts a capture.
    cycle_count_cfg = 0; d0 = delivered;
    repeat (4) step(1, 1, 1);
    step(0, 1, 1);
    check("zero_cnt", 256'(delivered - d0), 256'd0);

    // Trigger held high re-arms only after going low.
    cycle_count_cfg = 2; n0 = done_seen;
    repeat (20) step(1, 1, 1);
    check("held_trig_once", 256'(done_seen - n0), 256'd1);
    step(0, 1, 1);
    repeat (5) step(1, 1, 1);
    check("rearm_trig", 256'(done_seen - n0), 256'd2);
    step(0, 1, 1);

    // Reset on the 2nd beat of an 8-beat capture.
    cycle_count_cfg = 8; n0 = done_seen;
    step(1, 1, 1); step(0, 1, 1); step(0, 1, 1);
    do_reset();
    repeat (3) step(0, 1, 1);
    check("rst_no_done", 256'(done_seen - n0), 256'd0);
    d0 = delivered;
    step(1, 1, 1);
    repeat (10) step(0, 1, 1);
    check("post_rst_beats", 256'(delivered - d0), 256'd8);

`ifdef ADC_CTRL_TIMESTAMP_EN
    do_reset();
    cycle_count_cfg = 1; pre_delay_cfg = 0;
    repeat (100) step(0, 0, 1);
    step(1, 1, 1);
    repeat (4) step(0, 0, 1);
    check("ts_100", 256'(trig_timestamp), 256'd100);
`endif

    // Random traffic with changing cfg words.
    for (int c = 0; c < 400; c++) begin
      cycle_count_cfg = $urandom_range(0, 6);
      pre_delay_cfg = $urandom_range(0, 4);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
    end

    cycle_count_cfg = 0;
    repeat (5) step(0, 0, 1);
    check("queue_drained", 256'(exp_q.size()), 256'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/adc_ctrl.md
ADC_CTRL -- requirements
Module: adc_ctrl

Interface
REQ-001 Parameter CFG_W, default 32, width of the capture-length and pre-delay configuration words.
REQ-002 clk  input  1  250 MHz clock from the RFSoC IP; all logic is on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 s_axis_tdata  input  256  ADC sample beat from the RFSoC IP.
REQ-005 s_axis_tvalid  input  1  ADC beat valid.
REQ-006 s_axis_tready  output  1  held constant 1; the ADC stream is never stalled.
REQ-007 m_axis_tdata  output  256  captured beat to the capture fifo, registered.
REQ-008 m_axis_tvalid  output  1  captured beat valid, registered.
REQ-009 m_axis_tlast  output  1  marks the final beat of a capture.
REQ-010 m_axis_tready  input  1  capture fifo ready.
REQ-011 trigger_in  input  1  synchronization trigger, level-sampled.
REQ-012 cycle_count_cfg  input  CFG_W  number of beats to capture.
REQ-013 pre_delay_cfg  input  CFG_W  idle cycles between trigger and first capture edge.
REQ-014 capture_done  output  1  one-cycle pulse when a capture completes.
REQ-015 overflow_err  output  1  sticky flag: a beat was dropped for lack of m_axis_tready.

Function
REQ-016 The block SHALL implement states IDLE, PRE, CAPTURE, DONE.
REQ-017 IDLE: on an edge sampling trigger_in=1 with cycle_count_cfg!=0, latch both cfg words; go to CAPTURE if pre_delay_cfg==0, else PRE; with cycle_count_cfg==0, stay in IDLE.
REQ-018 Cfg changes after the trigger edge SHALL have no effect on the current capture.
REQ-019 PRE SHALL last exactly pre_delay_cfg cycles, then go to CAPTURE.
REQ-020 CAPTURE: each edge with s_axis_tvalid=1 is a sample edge; it decrements the remaining count by 1; edges with s_axis_tvalid=0 neither capture nor decrement.
REQ-021 On a sample edge with m_axis_tvalid=0, or with m_axis_tvalid=1 and m_axis_tready=1, m_axis_tdata<=s_axis_tdata and m_axis_tvalid<=1 (latency 1 cycle).
REQ-022 On a sample edge with m_axis_tvalid=1 and m_axis_tready=0, the incoming beat SHALL be discarded, m_axis_tdata held stable, overflow_err set; the count still decrements.
REQ-023 m_axis_tvalid SHALL clear on any edge with m_axis_tready=1 and no new beat loaded.
REQ-024 m_axis_tlast SHALL be 1 exactly while the beat from the final sample edge is presented.
REQ-025 After the final sample edge: capture_done pulses for one cycle, state goes to DONE.
REQ-026 DONE SHALL return to IDLE only on an edge sampling trigger_in=0; trigger_in held high never re-arms.
REQ-027 trigger_in SHALL be ignored in PRE, CAPTURE and DONE.
REQ-028 overflow_err SHALL clear only on the next accepted trigger in IDLE.
REQ-029 Counters SHALL be CFG_W+1 bits wide; no wrap-around for any cfg value up to 2^CFG_W-1.

Reset
REQ-030 rst=0 SHALL asynchronously force IDLE, counters 0, m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0, capture_done=0, overflow_err=0; s_axis_tready stays 1.
REQ-031 Reset mid-capture SHALL abandon the capture with no capture_done pulse.

Configuration
REQ-032 Macro ADC_CTRL_TIMESTAMP_EN defined: a free-running CFG_W-bit counter (reset 0, wraps) exists, and its value on the accepted trigger edge is latched into an added output trig_timestamp (CFG_W bits, reset 0).
REQ-033 Macro ADC_CTRL_TIMESTAMP_EN undefined: no counter and no trig_timestamp port; all other behaviour identical.

Verification
REQ-034 cycle_count_cfg=4, pre_delay_cfg=0, tvalid=1, tready=1, trigger pulse -> 4 beats equal to ADC beats on the 4 edges after the trigger edge, tlast on 4th, capture_done 1 cycle.
REQ-035 cycle_count_cfg=3, pre_delay_cfg=5 -> first captured beat is the ADC beat at the 6th edge after the trigger edge; 3 beats total.
REQ-036 cycle_count_cfg=4, tready=0 for beats 2-3 -> beat 1 held, overflow_err=1, 2 beats delivered, tlast on the last delivered beat.
REQ-037 trigger_in held high for 20 cycles, cycle_count_cfg=2 -> exactly one capture; second capture only after trigger_in low then high.
REQ-038 rst asserted on 2nd beat of an 8-beat capture -> all outputs 0 immediately, no capture_done; next trigger captures normally.
REQ-039 ADC_CTRL_TIMESTAMP_EN defined, trigger at timestamp counter value 100 -> trig_timestamp=100 until the next accepted trigger.
